alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 32 only).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port ALU_opcode  input  3  operation: SLT=000, ADD=001, SUB=010, AND=011, OR=100, SLL=101, SRL=110, XOR=111.
REQ-007 SHALL have port operand_a  input  XLEN  first operand.
REQ-008 SHALL have port operand_b  input  XLEN  second operand; bits [4:0] are the shift amount for SLL/SRL.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port zero  output  1  high when result == 0.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE), out_valid = (state == DONE), both decoded from registered state.
REQ-014 SHALL accept a request on an edge where in_valid && in_ready; opcode and operands captured at that edge; inputs ignored at all other times.
REQ-015 SHALL, for ADD/SUB/AND/OR/XOR/SLT, register the result at the accepting edge and go IDLE->DONE (latency 1: out_valid in the cycle after acceptance).
REQ-016 SHALL compute ADD/SUB modulo 2^XLEN (wrap, no overflow flag); SLT = 1 if signed(a) < signed(b), else 0, zero-extended.
REQ-017 SHALL, for SLL/SRL with shamt == 0, go IDLE->DONE with result = operand_a (latency 1).
REQ-018 SHALL, for SLL/SRL with shamt > 0, load accumulator = operand_a and count = shamt, go IDLE->SHIFT; each SHIFT cycle shift accumulator 1 bit (SRL zero-fills MSB) and decrement count; on the edge where count == 1 go SHIFT->DONE (latency 1 + shamt).
REQ-019 SHALL hold result and zero stable while in DONE; DONE->IDLE on edge with out_ready; out_valid SHALL not drop without out_ready.
REQ-020 SHALL ignore in_valid while in SHIFT or DONE (no queuing); next acceptance earliest the cycle after DONE->IDLE.
REQ-021 SHALL derive zero combinationally from the registered result.

Reset
REQ-022 SHALL, on rst_n low at any time (including mid-SHIFT or in DONE), go to IDLE, clear result, accumulator, count to 0; in-flight operation discarded.
REQ-023 SHALL drive reset values: in_ready=1, out_valid=0, result=0, zero=1.

Configuration
REQ-024 SHALL, with ALU_FAST_SHIFT_EN defined, compute SLL/SRL by a single-cycle barrel shifter, latency 1 for every shamt, SHIFT state unreachable.
REQ-025 SHALL, without ALU_FAST_SHIFT_EN, use the serial 1-bit/cycle shifter of REQ-018.

Structure
REQ-026 SHALL place opcode constants, FSM state encoding and XLEN default in shared package alu_pkg, also used by the opcode producer.
REQ-027 SHALL put accumulator/counter/shift logic in sub-module alu_serial_shifter (start, shamt, dir, operand in; done, value out); FSM and arithmetic stay in alu_exec_unit.

Verification
REQ-028 SHALL cover: ADD a=0xFFFFFFFF b=1 -> result=0, zero=1, out_valid 1 cycle after acceptance.
REQ-029 SHALL cover: SUB a=5 b=7 -> 0xFFFFFFFE; SLT a=0xFFFFFFFF b=1 -> 1; SLT a=1 b=0xFFFFFFFF -> 0.
REQ-030 SHALL cover: SLL a=1 b=31 -> 0x80000000, out_valid 32 cycles after acceptance (serial) / 1 cycle (ALU_FAST_SHIFT_EN); SRL a=0x80000000 b=0 -> 0x80000000, 1 cycle.
REQ-031 SHALL cover: out_ready held low 5 cycles in DONE -> result stable, in_ready=0, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-032 SHALL cover: rst_n pulsed low during SLL b=20 after 7 shift cycles -> out_valid=0, result=0, in_ready=1 immediately; subsequent XOR a=0xF0F0 b=0xFF00 -> 0x0FF0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, FSM state encoding and datapath defaults.
// Consumed by alu_exec_unit, alu_serial_shifter and the opcode producer.
package alu_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned STATE_W   = 2;

  localparam logic [OPCODE_W-1:0] OP_SLT = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_SLL = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_SRL = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b111;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_serial_shifter.sv
// Serial 1-bit-per-cycle logical shifter: loads operand and count on start,
// then shifts once per cycle until the count is exhausted.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic [XLEN-1:0]    operand,
  output logic               done,
  output logic [XLEN-1:0]    value
);

  logic [XLEN-1:0]    acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;

  // value is the accumulator after this cycle's shift; done flags the final step
  assign value = dir_q ? (acc_q >> 1) : (acc_q << 1);
  assign done  = (cnt_q == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else if (start) begin
      acc_q <= operand;
      cnt_q <= shamt;
      dir_q <= dir;
    end else if (cnt_q != '0) begin
      acc_q <= value;
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake; shifts run serially unless
// ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] ALU_opcode,
  input  logic [XLEN-1:0]     operand_a,
  input  logic [XLEN-1:0]     operand_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result,
  output logic                zero
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [XLEN-1:0]    alu_c;
  logic [SHAMT_W-1:0] shamt;
  logic               serial_c;
  logic               start_c;
  logic               shift_done;
  logic [XLEN-1:0]    shift_value;

  assign shamt = operand_b[SHAMT_W-1:0];

`ifdef ALU_FAST_SHIFT_EN
  assign serial_c    = 1'b0;
  assign shift_done  = 1'b0;
  assign shift_value = '0;
`else
  logic is_shift;
  assign is_shift = (ALU_opcode == OP_SLL) || (ALU_opcode == OP_SRL);
  assign serial_c = is_shift && (shamt != '0);

  alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_c),
    .shamt   (shamt),
    .dir     (ALU_opcode == OP_SRL),
    .operand (operand_a),
    .done    (shift_done),
    .value   (shift_value)
  );
`endif

  // Single-cycle operations; serial shifts only reach here with shamt == 0
  always_comb begin
    alu_c = '0;
    case (ALU_opcode)
      OP_SLT: alu_c = XLEN'($signed(operand_a) < $signed(operand_b));
      OP_ADD: alu_c = operand_a + operand_b;
      OP_SUB: alu_c = operand_a - operand_b;
      OP_AND: alu_c = operand_a & operand_b;
      OP_OR:  alu_c = operand_a | operand_b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: alu_c = operand_a << shamt;
      OP_SRL: alu_c = operand_a >> shamt;
`else
      OP_SLL: alu_c = operand_a;
      OP_SRL: alu_c = operand_a;
`endif
      OP_XOR: alu_c = operand_a ^ operand_b;
      default: alu_c = '0;
    endcase
  end

  // Next-state and result update
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    start_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (serial_c) begin
            start_c = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_c;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          result_d = shift_value;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule
